bus_master_port: RTL and testbench

- Master-side bus port that sits directly upstream of slave_wrapper.
- Accepts one parallel read or write request from the master core.
- Serialises the address, and for writes the data, onto the serial bus lines that feed the slave's rx_address/rx_data inputs.
- Waits for the slave's acknowledge. For reads, deserialises the slave's returned data and hands a parallel response back to the core.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_master_port_if.sv | 43 ++++
 rtl/bus_shift_reg.sv | 38 +++
 rtl/bus_master_port.sv | 158 +++++++++++++++
 tb/tb_bus_master_port.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared defaults and master FSM state type for the bus master port.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  // Encodings kept identical to the legacy port so state probes still decode.
  localparam logic [2:0] IDLE_ENC     = 3'd0;
  localparam logic [2:0] SHIFT_ENC    = 3'd1;
  localparam logic [2:0] WAIT_ACK_ENC = 3'd2;
  localparam logic [2:0] WAIT_RD_ENC  = 3'd3;
  localparam logic [2:0] RECV_ENC     = 3'd4;
  localparam logic [2:0] RESP_ENC     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE_ENC,
    ST_SHIFT    = SHIFT_ENC,
    ST_WAIT_ACK = WAIT_ACK_ENC,
    ST_WAIT_RD  = WAIT_RD_ENC,
    ST_RECV     = RECV_ENC,
    ST_RESP     = RESP_ENC
  } bus_mstate_t;

endpackage

// File: rtl/bus_master_port_if.sv
// Core request/response handshake plus serial bus lines of the bus master port.
// master: the port itself; slave: the core and downstream slave seen together.
interface bus_master_port_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              write_enable;
  logic              read_enable;
  logic              m_valid;
  logic              m_address;
  logic              m_data;
  logic              m_ready;
  logic              s_valid;
  logic              s_ready;
  logic              s_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           s_valid, s_ready, s_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           write_enable, read_enable, m_valid, m_address, m_data, m_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           s_valid, s_ready, s_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           write_enable, read_enable, m_valid, m_address, m_data, m_ready
  );

endinterface

// File: rtl/bus_shift_reg.sv
// Loadable right-shift register with bit counter: serial out at q[0] (PISO),
// serial in at the MSB (SIPO, LSB-first data ends up aligned after W shifts).
module bus_shift_reg #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          shift_en,
  input  logic          shift_in,
  output logic [W-1:0]  q,
  output logic [CW-1:0] count
);

  logic [W-1:0] q_shifted;

  if (W == 1) begin : g_w1
    assign q_shifted = shift_in;
  end else begin : g_wn
    assign q_shifted = {shift_in, q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q     <= '0;
      count <= '0;
    end else if (load) begin
      q     <= load_val;
      count <= '0;
    end else if (shift_en) begin
      q     <= q_shifted;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: one parallel request in, serial addr/data out,
// serial read data back in. Optional slave-response timeout: BUS_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  bus_master_port_if.master bus
);

  localparam int unsigned    ACW    = $clog2(ADDR_W + 1);
  localparam int unsigned    RCW    = $clog2(DATA_W + 1);
  localparam logic [ACW-1:0] A_LAST = ACW'(ADDR_W - 1);
  localparam logic [RCW-1:0] R_LAST = RCW'(DATA_W - 1);

  if (DATA_W > ADDR_W) begin : g_param_check
    $error("bus_master_port: DATA_W (%0d) must not exceed ADDR_W (%0d)", DATA_W, ADDR_W);
  end

  bus_mstate_t       state, state_nxt;
  logic              wr_q, err_q;
  logic              accept, shifting, sh_last, waiting, resp;
  logic              rd_cap, rd_last, tmo_exp, tmo_fire;
  logic [ADDR_W-1:0] a_q, d_q;
  logic [ACW-1:0]    a_cnt, d_cnt;
  logic [DATA_W-1:0] r_q;
  logic [RCW-1:0]    r_cnt;
  logic              unused_bits;

  assign accept   = (state == ST_IDLE) && bus.req_valid;
  assign shifting = (state == ST_SHIFT);
  assign sh_last  = shifting && (a_cnt == A_LAST);
  assign waiting  = (state == ST_WAIT_ACK) || (state == ST_WAIT_RD) || (state == ST_RECV);
  assign resp     = (state == ST_RESP);
  assign rd_cap   = ((state == ST_WAIT_RD) || (state == ST_RECV)) && bus.s_valid;
  assign rd_last  = rd_cap && (r_cnt == R_LAST);

  bus_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .load_val (bus.req_addr),
    .shift_en (shifting),
    .shift_in (1'b0),
    .q        (a_q),
    .count    (a_cnt)
  );

  // Write data is zero-extended to the address length so m_data reads 0 past DATA_W.
  bus_shift_reg #(.W(ADDR_W)) u_wdata_sr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .load_val (bus.req_write ? ADDR_W'(bus.req_wdata) : '0),
    .shift_en (shifting),
    .shift_in (1'b0),
    .q        (d_q),
    .count    (d_cnt)
  );

  bus_shift_reg #(.W(DATA_W)) u_rdata_sr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .load_val ('0),
    .shift_en (rd_cap),
    .shift_in (bus.s_rdata),
    .q        (r_q),
    .count    (r_cnt)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_exp = waiting && (tmo_cnt == TMO_LAST);

  // Restarts on every state change (entry into each wait state) and on each captured bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if ((state_nxt != state) || rd_cap) begin
      tmo_cnt <= '0;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic [31:0] unused_tmo_cyc;
  assign unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_exp        = 1'b0;
`endif

  assign unused_bits = ^{a_q, d_q, d_cnt, waiting};

  // A captured bit or ack always takes priority over an expiring timeout.
  always_comb begin
    state_nxt = state;
    tmo_fire  = 1'b0;
    unique case (state)
      ST_IDLE:     if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT:    if (sh_last) state_nxt = wr_q ? ST_WAIT_ACK : ST_WAIT_RD;
      ST_WAIT_ACK: begin
        if (bus.s_ready) begin
          state_nxt = ST_RESP;
        end else if (tmo_exp) begin
          state_nxt = ST_RESP;
          tmo_fire  = 1'b1;
        end
      end
      ST_WAIT_RD, ST_RECV: begin
        if (rd_last) begin
          state_nxt = ST_RESP;
        end else if (rd_cap) begin
          state_nxt = ST_RECV;
        end else if (tmo_exp) begin
          state_nxt = ST_RESP;
          tmo_fire  = 1'b1;
        end
      end
      ST_RESP:     if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q  <= bus.req_write;
        err_q <= 1'b0;
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.m_valid      = shifting;
  assign bus.m_address    = shifting & a_q[0];
  assign bus.m_data       = shifting & d_q[0];
  assign bus.write_enable = shifting && (a_cnt == '0) && wr_q;
  assign bus.read_enable  = shifting && (a_cnt == '0) && !wr_q;
  assign bus.m_ready      = (state == ST_WAIT_RD) || (state == ST_RECV);
  assign bus.rsp_valid    = resp;
  assign bus.rsp_err      = resp && err_q;
  assign bus.rsp_rdata    = (resp && !wr_q && !err_q) ? r_q : '0;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: transaction-level model compared every
// cycle, plus directed transfers with hand-computed expectations.
module tb_bus_master_port;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO    = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is busy from accept until its response is taken.
  logic              mbusy, mwr, mresp, merr;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwd, mrxd;
  int unsigned       msh, mrx;
`ifdef BUS_TIMEOUT_EN
  int unsigned       mwt;
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mbusy <= 1'b0; mwr <= 1'b0; mresp <= 1'b0; merr <= 1'b0;
      maddr <= '0; mwd <= '0; mrxd <= '0; msh <= 0; mrx <= 0;
`ifdef BUS_TIMEOUT_EN
      mwt <= 0;
`endif
    end else if (!mbusy) begin
      if (bus.req_valid) begin
        mbusy <= 1'b1; mwr <= bus.req_write; maddr <= bus.req_addr; mwd <= bus.req_wdata;
        msh <= 0; mresp <= 1'b0; merr <= 1'b0; mrx <= 0; mrxd <= '0;
`ifdef BUS_TIMEOUT_EN
        mwt <= 0;
`endif
      end
    end else if (msh < ADDR_W) begin
      msh <= msh + 1;
    end else if (mresp) begin
      if (bus.rsp_ready) mbusy <= 1'b0;
    end else if (mwr && bus.s_ready) begin
      mresp <= 1'b1;
    end else if (!mwr && bus.s_valid) begin
      mrxd <= mrxd | (DATA_W'(bus.s_rdata) << mrx);
      mrx  <= mrx + 1;
      if (mrx == DATA_W - 1) mresp <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      mwt <= 0;
    end else if (mwt == TMO - 1) begin
      mresp <= 1'b1;
      merr  <= 1'b1;
    end else begin
      mwt <= mwt + 1;
`endif
    end
  end

  logic e_mv, e_rv;
  always @(negedge clk) begin
    if (chk_en) begin
      e_mv = mbusy && (msh < ADDR_W);
      e_rv = mbusy && mresp;
      cmp("req_ready", bus.req_ready, !mbusy);
      cmp("m_valid", bus.m_valid, e_mv);
      cmp("m_address", bus.m_address, e_mv ? 1'(maddr >> msh) : 1'b0);
      cmp("m_data", bus.m_data, (e_mv && mwr) ? 1'(mwd >> msh) : 1'b0);
      cmp("write_enable", bus.write_enable, e_mv && (msh == 0) && mwr);
      cmp("read_enable", bus.read_enable, e_mv && (msh == 0) && !mwr);
      cmp("m_ready", bus.m_ready, mbusy && (msh == ADDR_W) && !mresp && !mwr);
      cmp("rsp_valid", bus.rsp_valid, e_rv);
      cmp("rsp_err", bus.rsp_err, e_rv && merr);
      cmp("rsp_rdata", bus.rsp_rdata, (e_rv && !mwr && !merr) ? mrxd : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    while (!bus.req_ready && n < 200) begin tick(); n++; end
    cmp("req_ready_wait", bus.req_ready, 1'b1);
    bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_shift(output logic [ADDR_W-1:0] av, output logic [ADDR_W-1:0] dv,
                           output int we, output int re, output int mv);
    av = '0; dv = '0; we = 0; re = 0; mv = 0;
    for (int i = 0; i < ADDR_W; i++) begin
      av = av | (ADDR_W'(bus.m_address) << i);
      dv = dv | (ADDR_W'(bus.m_data) << i);
      we += int'(bus.write_enable);
      re += int'(bus.read_enable);
      mv += int'(bus.m_valid);
      tick();
    end
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] d, input int stall_at, input int stall_len);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == stall_at) begin
        for (int j = 0; j < stall_len; j++) begin
          bus.s_valid = 1'b0; bus.s_rdata = ~1'(d >> i); tick();
        end
      end
      bus.s_valid = 1'b1; bus.s_rdata = 1'(d >> i); tick();
    end
    bus.s_valid = 1'b0; bus.s_rdata = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 300) begin tick(); n++; end
    cmp("rsp_wait", bus.rsp_valid, 1'b1);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    cmp("req_ready_after_rsp", bus.req_ready, 1'b1);
  endtask

  logic [ADDR_W-1:0] av, dv;
  int we, re, mv, n, cnt;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.s_valid = 1'b0; bus.s_ready = 1'b0; bus.s_rdata = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_req_ready", bus.req_ready, 1'b1);
    cmp("reset_outputs_zero", {bus.rsp_valid, bus.rsp_err, bus.write_enable, bus.read_enable,
        bus.m_valid, bus.m_address, bus.m_data, bus.m_ready, bus.rsp_rdata}, '0);
    chk_en = 1'b1;
    rstn = 1'b1;
    tick();

    // Write 9B5 / 79, ack two cycles after the shift ends
    start_req(1'b1, 12'h9B5, 8'h79);
    run_shift(av, dv, we, re, mv);
    cmp("wr_addr_bits", av, 12'h9B5);
    cmp("wr_data_bits", dv, 12'h079);
    cmp("wr_we_pulses", we, 1);
    cmp("wr_re_pulses", re, 0);
    cmp("wr_mvalid_cycles", mv, 12);
    cmp("wr_mvalid_fall", bus.m_valid, 1'b0);
    tick(); tick();
    bus.s_ready = 1'b1; tick(); bus.s_ready = 1'b0;
    wait_rsp(n);
    cmp("wr_rsp_err", bus.rsp_err, 1'b0);
    cmp("wr_rsp_rdata", bus.rsp_rdata, 8'h00);
    handshake();

    // Read 003 returning A5
    start_req(1'b0, 12'h003, 8'hFF);
    run_shift(av, dv, we, re, mv);
    cmp("rd_addr_bits", av, 12'h003);
    cmp("rd_mdata_zero", dv, 12'h000);
    cmp("rd_re_pulses", re, 1);
    cmp("rd_m_ready_start", bus.m_ready, 1'b1);
    send_bits(8'hA5, -1, 0);
    wait_rsp(n);
    cmp("rd_rsp_latency", n, 0);
    cmp("rd_rdata_A5", bus.rsp_rdata, 8'hA5);
    cmp("rd_m_ready_end", bus.m_ready, 1'b0);
    handshake();

    // Read with a 3-cycle s_valid gap after four bits
    start_req(1'b0, 12'h7E1, 8'h00);
    run_shift(av, dv, we, re, mv);
    send_bits(8'h3C, 4, 3);
    wait_rsp(n);
    cmp("stall_rdata_3C", bus.rsp_rdata, 8'h3C);
    handshake();

    // Response held while the core stalls; a new request must not be accepted
    start_req(1'b0, 12'h5A0, 8'h00);
    run_shift(av, dv, we, re, mv);
    send_bits(8'hC3, -1, 0);
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1;
      cmp("hold_rsp_valid", bus.rsp_valid, 1'b1);
      cmp("hold_rdata", bus.rsp_rdata, 8'hC3);
      cmp("hold_req_ready", bus.req_ready, 1'b0);
      tick();
    end
    bus.req_valid = 1'b0;
    handshake();
    cmp("hold_rsp_dropped", bus.rsp_valid, 1'b0);

    // Write with s_ready held high throughout: stray while idle/shifting, ack at once
    bus.s_ready = 1'b1;
    bus.req_write = 1'b1; bus.req_addr = 12'h0F0; bus.req_wdata = 8'h0F; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 100) begin tick(); n++; end
    cmp("wr_latency", n, ADDR_W + 2);
    bus.s_ready = 1'b0;
    handshake();

`ifdef BUS_TIMEOUT_EN
    // Write never acknowledged
    start_req(1'b1, 12'h2C4, 8'h11);
    run_shift(av, dv, we, re, mv);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin tick(); n++; end
    cmp("tmo_cycles", n, TMO);
    cmp("tmo_err", bus.rsp_err, 1'b1);
    cmp("tmo_rdata", bus.rsp_rdata, 8'h00);
    handshake();
`endif

    // Reset in SHIFT cycle 5
    start_req(1'b1, 12'hABC, 8'h55);
    repeat (5) tick();
    cmp("pre_reset_m_valid", bus.m_valid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    cmp("rst_req_ready", bus.req_ready, 1'b1);
    cmp("rst_outputs_zero", {bus.rsp_valid, bus.rsp_err, bus.write_enable, bus.read_enable,
        bus.m_valid, bus.m_address, bus.m_data, bus.m_ready, bus.rsp_rdata}, '0);
    tick();
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(bus.rsp_valid) + int'(bus.m_valid);
      tick();
    end
    cmp("post_reset_quiet", cnt, 0);
    cmp("post_reset_req_ready", bus.req_ready, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
